// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped 8N1 UART transmitter for the 6502 bus: CPU writes to DATA_ADDR feed
// a TX FIFO, a four-state FSM serialises bytes, and STATUS_ADDR exposes FIFO/FSM state.
module uart_mmio_ctrl #(
  parameter logic [15:0] DATA_ADDR    = 16'h0F00,
  parameter logic [15:0] STATUS_ADDR  = 16'h0F01,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_addr,
  input  logic        i_rw,
  input  logic [7:0]  i_wdata,
  output logic [7:0]  o_rdata,
  output logic        o_sel,
  output logic        o_tx,
  output logic        o_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state, state_n;
  logic [CW-1:0]  clk_cnt, clk_cnt_n;
  logic [2:0]     bit_idx, bit_idx_n;
  logic [7:0]     shift, shift_n;
  logic           tx_n, busy_n;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic           full, empty, push_req, push, pop, overflow;
  logic           rd_hit, st_wr, bit_end;
  logic [7:0]     head, status;

  // Pointers carry one extra MSB: equal -> empty, only MSB differs -> full.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ((wr_ptr ^ rd_ptr) == (AW+1)'(FIFO_DEPTH));
  assign push_req = !i_rw && (i_addr == DATA_ADDR);
  assign push     = push_req && !full;
  assign st_wr    = !i_rw && (i_addr == STATUS_ADDR);
  assign rd_hit   = i_rw && ((i_addr == DATA_ADDR) || (i_addr == STATUS_ADDR));
  assign head     = mem[rd_ptr[AW-1:0]];
  assign status   = {4'b0, overflow, state != IDLE, empty, full};
  assign bit_end  = (clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign wr_ptr_n = wr_ptr + (AW+1)'(push);
  assign rd_ptr_n = rd_ptr + (AW+1)'(pop);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_wdata;
  end

  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          shift_n   = head;
          clk_cnt_n = '0;
          state_n   = START;
        end
      end
      START: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          bit_idx_n = '0;
          state_n   = DATA;
        end else clk_cnt_n = clk_cnt + 1'b1;
      end
      DATA: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          shift_n   = shift >> 1;
          if (bit_idx == 3'd7) state_n = STOP;
          else bit_idx_n = bit_idx + 1'b1;
        end else clk_cnt_n = clk_cnt + 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          clk_cnt_n = '0;
          // Chain straight into the next start bit so frames stay contiguous.
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            state_n = START;
          end else state_n = IDLE;
        end else clk_cnt_n = clk_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    tx_n   = (state_n == START) ? 1'b0 : (state_n == DATA) ? shift_n[0] : 1'b1;
    busy_n = (wr_ptr_n != rd_ptr_n) || (state_n != IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      o_tx     <= 1'b1;
      o_busy   <= 1'b0;
      o_rdata  <= 8'h00;
      o_sel    <= 1'b0;
    end else begin
      state   <= state_n;
      clk_cnt <= clk_cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      o_tx    <= tx_n;
      o_busy  <= busy_n;
      if (push_req && full) overflow <= 1'b1;
      else if (st_wr)       overflow <= 1'b0;
      o_sel <= rd_hit;
      if (rd_hit) o_rdata <= (i_addr == STATUS_ADDR) ? status : 8'h00;
    end
  end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl at CLKS_PER_BIT=4: reset, framing, chaining,
// overflow, decode isolation and asynchronous reset mid-frame.
module tb_uart_mmio_ctrl;

  localparam int CPB = 4;
  localparam logic [15:0] DA = 16'h0F00;
  localparam logic [15:0] SA = 16'h0F01;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [15:0] i_addr = 16'h0000;
  logic        i_rw = 1'b1;
  logic [7:0]  i_wdata = 8'h00;
  logic [7:0]  o_rdata;
  logic        o_sel, o_tx, o_busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] bq [16];

  uart_mmio_ctrl #(.DATA_ADDR(DA), .STATUS_ADDR(SA), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_addr(i_addr), .i_rw(i_rw), .i_wdata(i_wdata),
    .o_rdata(o_rdata), .o_sel(o_sel), .o_tx(o_tx), .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
    @(negedge i_clk); i_addr = a; i_rw = 1'b0; i_wdata = d;
    @(negedge i_clk); i_addr = 16'h0000; i_rw = 1'b1;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [7:0] d, output logic s);
    @(negedge i_clk); i_addr = a; i_rw = 1'b1;
    @(negedge i_clk); d = o_rdata; s = o_sel; i_addr = 16'h0000;
  endtask

  task automatic burst(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk); i_addr = DA; i_rw = 1'b0; i_wdata = bq[i];
    end
    @(negedge i_clk); i_addr = 16'h0000; i_rw = 1'b1;
  endtask

  // Caller sits on a negedge; samples mid-bit relative to the first low sample.
  task automatic rx_byte(output logic [7:0] b);
    int n = 0;
    while (o_tx !== 1'b0 && n < 600) begin @(negedge i_clk); n++; end
    chk("rx_timeout", 32'(n < 600), 32'd1);
    repeat (6) @(negedge i_clk);
    b[0] = o_tx;
    for (int i = 1; i < 8; i++) begin repeat (CPB) @(negedge i_clk); b[i] = o_tx; end
    repeat (CPB) @(negedge i_clk);
    chk("rx_stop", 32'(o_tx), 32'd1);
  endtask

  initial begin
    logic [7:0] d, rb;
    logic       s;
    logic [3:0] smp;
    logic [9:0] frame;
    logic [7:0] rxq [9];
    int         lows;

    // Reset
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_tx", 32'(o_tx), 32'd1);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_sel", 32'(o_sel), 32'd0);
    chk("rst_rdata", 32'(o_rdata), 32'h00);
    i_rst_n = 1'b1;
    bus_read(SA, d, s);
    chk("rst_stat_sel", 32'(s), 32'd1);
    chk("rst_stat", 32'(d), 32'h02);

    // Single byte 0x41: exact waveform, 4 samples per bit
    @(negedge i_clk); i_addr = DA; i_rw = 1'b0; i_wdata = 8'h41;
    @(negedge i_clk); i_addr = 16'h0000; i_rw = 1'b1;
    chk("lat_pre_tx", 32'(o_tx), 32'd1);
    chk("lat_pre_busy", 32'(o_busy), 32'd1);
    frame = {1'b1, 8'h41, 1'b0};
    for (int p = 0; p < 10; p++) begin
      for (int j = 0; j < 4; j++) begin @(negedge i_clk); smp[j] = o_tx; end
      chk($sformatf("f41_bit%0d", p), 32'(smp), frame[p] ? 32'hF : 32'h0);
    end
    chk("f41_busy_last", 32'(o_busy), 32'd1);
    @(negedge i_clk);
    chk("f41_busy_fall", 32'(o_busy), 32'd0);
    chk("f41_idle_tx", 32'(o_tx), 32'd1);

    // Back-to-back 0x55, 0xAA
    bq[0] = 8'h55; bq[1] = 8'hAA;
    burst(2);
    rx_byte(rb);
    chk("b2b_byte0", 32'(rb), 32'h55);
    @(negedge i_clk);
    chk("b2b_stop_tail", 32'(o_tx), 32'd1);
    @(negedge i_clk);
    chk("b2b_contig", 32'(o_tx), 32'd0);
    rx_byte(rb);
    chk("b2b_byte1", 32'(rb), 32'hAA);
    repeat (10) @(negedge i_clk);
    chk("b2b_idle_busy", 32'(o_busy), 32'd0);

    // Overflow: 0x00 pops at once, 0x01..0x08 fill the FIFO, 0x09 is dropped
    for (int i = 0; i < 10; i++) bq[i] = 8'(i);
    fork
      begin
        burst(10);
        bus_read(SA, d, s);
        chk("ovf_stat", 32'(d), 32'h0D);
        bus_write(SA, 8'h00);
        bus_read(SA, d, s);
        chk("ovf_clr_stat", 32'(d), 32'h05);
      end
      begin
        for (int i = 0; i < 9; i++) rx_byte(rxq[i]);
      end
    join
    for (int i = 0; i < 9; i++) chk($sformatf("ovf_rx%0d", i), 32'(rxq[i]), i);
    repeat (60) @(negedge i_clk);
    chk("ovf_drained_busy", 32'(o_busy), 32'd0);
    bus_read(SA, d, s);
    chk("ovf_drained_stat", 32'(d), 32'h02);

    // Decode isolation
    bus_write(16'h0F02, 8'hFF);
    bus_write(16'h0E00, 8'h77);
    bus_read(SA, d, s);
    chk("dec_stat", 32'(d), 32'h02);
    bus_read(16'h1000, d, s);
    chk("dec_far_sel", 32'(s), 32'd0);
    chk("dec_far_hold", 32'(d), 32'h02);
    chk("dec_busy", 32'(o_busy), 32'd0);
    chk("dec_tx", 32'(o_tx), 32'd1);
    bus_read(DA, d, s);
    chk("dec_data_sel", 32'(s), 32'd1);
    chk("dec_data_rd", 32'(d), 32'h00);

    // Asynchronous reset during data bit 3 of 0xA5 (bit3 = 0)
    bus_write(DA, 8'hA5);
    repeat (18) @(negedge i_clk);
    chk("arst_pre_bit3", 32'(o_tx), 32'd0);
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_tx", 32'(o_tx), 32'd1);
    chk("arst_busy", 32'(o_busy), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    bus_read(SA, d, s);
    chk("arst_stat", 32'(d), 32'h02);
    lows = 0;
    for (int i = 0; i < 60; i++) begin @(negedge i_clk); if (o_tx !== 1'b1) lows++; end
    chk("arst_no_frame", lows, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
